// File: rtl/dphy_clk_lane_tx.sv
// MIPI D-PHY transmit clock-lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> clock -> HS-0 -> LP-11.
// Define DPHY_CLK_LANE_TX_CONT_CLK_EN for continuous-clock mode (lane stays in HS once running).
module dphy_clk_lane_tx #(
    parameter int T_LPX     = 2,
    parameter int T_PREPARE = 3,
    parameter int T_ZERO    = 8,
    parameter int T_PRE     = 2,
    parameter int T_POST    = 16,
    parameter int T_TRAIL   = 3,
    parameter int T_EXIT    = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hs_req_i,
    output logic lp_p_o,
    output logic lp_n_o,
    output logic hs_oe_o,
    output logic hs_clk_en_o,
    output logic hs_ready_o,
    output logic idle_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LP01     = 4'd1,
        S_LP00     = 4'd2,
        S_HS_ZERO  = 4'd3,
        S_HS_PRE   = 4'd4,
        S_HS_RUN   = 4'd5,
        S_HS_POST  = 4'd6,
        S_HS_TRAIL = 4'd7,
        S_EXIT     = 4'd8
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // Counter preload for a freshly entered state; untimed states park at zero.
    function automatic logic [7:0] load_for(input state_t s);
        case (s)
            S_LP01:     return 8'(T_LPX - 1);
            S_LP00:     return 8'(T_PREPARE - 1);
            S_HS_ZERO:  return 8'(T_ZERO - 1);
            S_HS_PRE:   return 8'(T_PRE - 1);
            S_HS_POST:  return 8'(T_POST - 1);
            S_HS_TRAIL: return 8'(T_TRAIL - 1);
            S_EXIT:     return 8'(T_EXIT - 1);
            default:    return 8'd0;
        endcase
    endfunction

    // Next-state and timer update; the request is only looked at in IDLE and HS_RUN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE:     state_nxt = hs_req_i ? S_LP01 : S_IDLE;
            S_LP01:     state_nxt = (cnt == 8'd0) ? S_LP00 : S_LP01;
            S_LP00:     state_nxt = (cnt == 8'd0) ? S_HS_ZERO : S_LP00;
            S_HS_ZERO:  state_nxt = (cnt == 8'd0) ? S_HS_PRE : S_HS_ZERO;
            S_HS_PRE:   state_nxt = (cnt == 8'd0) ? S_HS_RUN : S_HS_PRE;
`ifdef DPHY_CLK_LANE_TX_CONT_CLK_EN
            S_HS_RUN:   state_nxt = S_HS_RUN;
`else
            S_HS_RUN:   state_nxt = hs_req_i ? S_HS_RUN : S_HS_POST;
`endif
            S_HS_POST:  state_nxt = (cnt == 8'd0) ? S_HS_TRAIL : S_HS_POST;
            S_HS_TRAIL: state_nxt = (cnt == 8'd0) ? S_EXIT : S_HS_TRAIL;
            S_EXIT:     state_nxt = (cnt == 8'd0) ? S_IDLE : S_EXIT;
            default:    state_nxt = S_IDLE;
        endcase
        if (state_nxt != state) begin
            cnt_nxt = load_for(state_nxt);
        end else if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
        end else begin
            cnt_nxt = cnt;
        end
    end

    // State, timer and outputs; outputs decode the next state so they change on the entry edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            lp_p_o      <= 1'b1;
            lp_n_o      <= 1'b1;
            hs_oe_o     <= 1'b0;
            hs_clk_en_o <= 1'b0;
            hs_ready_o  <= 1'b0;
            idle_o      <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lp_p_o      <= (state_nxt == S_IDLE) || (state_nxt == S_EXIT);
            lp_n_o      <= (state_nxt == S_IDLE) || (state_nxt == S_EXIT) || (state_nxt == S_LP01);
            hs_oe_o     <= (state_nxt == S_HS_ZERO) || (state_nxt == S_HS_PRE) ||
                           (state_nxt == S_HS_RUN)  || (state_nxt == S_HS_POST) ||
                           (state_nxt == S_HS_TRAIL);
            hs_clk_en_o <= (state_nxt == S_HS_PRE) || (state_nxt == S_HS_RUN) ||
                           (state_nxt == S_HS_POST);
            hs_ready_o  <= (state_nxt == S_HS_RUN);
            idle_o      <= (state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_dphy_clk_lane_tx.sv
// Self-checking bench for dphy_clk_lane_tx: timeline-queue model checked every cycle plus literal checkpoints.
module tb_dphy_clk_lane_tx;

    localparam int T_LPX     = 2;
    localparam int T_PREPARE = 3;
    localparam int T_ZERO    = 8;
    localparam int T_PRE     = 2;
    localparam int T_POST    = 16;
    localparam int T_TRAIL   = 3;
    localparam int T_EXIT    = 4;

    // Output vector layout: {lp_p, lp_n, hs_oe, hs_clk_en, hs_ready, idle}
    localparam logic [5:0] V_IDLE  = 6'b110001;
    localparam logic [5:0] V_LP01  = 6'b010000;
    localparam logic [5:0] V_LP00  = 6'b000000;
    localparam logic [5:0] V_ZERO  = 6'b001000;
    localparam logic [5:0] V_PRE   = 6'b001100;
    localparam logic [5:0] V_RUN   = 6'b001110;
    localparam logic [5:0] V_POST  = 6'b001100;
    localparam logic [5:0] V_TRAIL = 6'b001000;
    localparam logic [5:0] V_EXIT  = 6'b110000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_req = 1'b0;
    logic lp_p, lp_n, hs_oe, hs_clk_en, hs_ready, idle;

    int n_vec  = 0;
    int n_fail = 0;

    dphy_clk_lane_tx #(
        .T_LPX(T_LPX), .T_PREPARE(T_PREPARE), .T_ZERO(T_ZERO), .T_PRE(T_PRE),
        .T_POST(T_POST), .T_TRAIL(T_TRAIL), .T_EXIT(T_EXIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .hs_req_i(hs_req),
        .lp_p_o(lp_p),
        .lp_n_o(lp_n),
        .hs_oe_o(hs_oe),
        .hs_clk_en_o(hs_clk_en),
        .hs_ready_o(hs_ready),
        .idle_o(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outv();
        return {lp_p, lp_n, hs_oe, hs_clk_en, hs_ready, idle};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: a queue of the output vectors the lane must show on upcoming edges.
    logic [5:0] q[$];
    logic       running  = 1'b0;
    logic       model_ok = 1'b0;
    logic [5:0] exp_v    = V_IDLE;

    task automatic push_n(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) q.push_back(v);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            running  = 1'b0;
            exp_v    = V_IDLE;
            model_ok = 1'b1;
        end else begin
            if (q.size() == 0) begin
                if (running) begin
`ifndef DPHY_CLK_LANE_TX_CONT_CLK_EN
                    if (!hs_req) begin
                        push_n(V_POST, T_POST);
                        push_n(V_TRAIL, T_TRAIL);
                        push_n(V_EXIT, T_EXIT);
                        push_n(V_IDLE, 1);
                        running = 1'b0;
                    end
`endif
                end else if (hs_req) begin
                    push_n(V_LP01, T_LPX);
                    push_n(V_LP00, T_PREPARE);
                    push_n(V_ZERO, T_ZERO);
                    push_n(V_PRE, T_PRE);
                    push_n(V_RUN, 1);
                    running = 1'b1;
                end
            end
            if (q.size() != 0) exp_v = q.pop_front();
            else               exp_v = running ? V_RUN : V_IDLE;
        end
    end

    always @(negedge clk) begin
        if (model_ok) chk("model", outv(), exp_v);
    end

    // Advance n active edges and land 3 time units after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    int ready_cnt;

    initial begin
        // Reset held 3 cycles with request high.
        rst = 1'b1; hs_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_hold", outv(), V_IDLE);
        end
        rst = 1'b0; hs_req = 1'b0;
        tick(2);
        chk("idle_after_reset", outv(), V_IDLE);

        // Startup: request sampled at edge E.
        hs_req = 1'b1;
        tick(1);  chk("start_E_lp01", outv(), 6'b010000);
        tick(1);  chk("start_E1_lp01", outv(), 6'b010000);
        tick(1);  chk("start_E2_lp00", outv(), 6'b000000);
        tick(3);  chk("start_E5_zero", outv(), 6'b001000);
        tick(8);  chk("start_E13_pre", outv(), 6'b001100);
        tick(1);  chk("start_E14_pre", outv(), 6'b001100);
        tick(1);  chk("start_E15_ready", outv(), 6'b001110);
        tick(3);  chk("run_hold", outv(), 6'b001110);

`ifdef DPHY_CLK_LANE_TX_CONT_CLK_EN
        hs_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("cont_run", outv(), 6'b001110);
        end
        rst = 1'b1;
        tick(1);  chk("cont_reset", outv(), 6'b110001);
        rst = 1'b0;
        tick(2);  chk("cont_idle", outv(), 6'b110001);
`else
        // Shutdown: drop sampled at edge F.
        hs_req = 1'b0;
        tick(1);  chk("stop_F_post", outv(), 6'b001100);
        tick(15); chk("stop_F15_post", outv(), 6'b001100);
        tick(1);  chk("stop_F16_trail", outv(), 6'b001000);
        tick(3);  chk("stop_F19_exit", outv(), 6'b110000);
        tick(3);  chk("stop_F22_exit", outv(), 6'b110000);
        tick(1);  chk("stop_F23_idle", outv(), 6'b110001);
        tick(2);

        // Short pulse: one sampled cycle of request.
        hs_req = 1'b1;
        tick(1);
        hs_req = 1'b0;
        ready_cnt = 0;
        for (int i = 1; i <= 45; i++) begin
            tick(1);
            if (hs_ready) ready_cnt++;
            if (i == 15) chk("pulse_ready_rise", outv(), 6'b001110);
            if (i == 16) chk("pulse_post", outv(), 6'b001100);
            if (i == 38) chk("pulse_exit_end", outv(), 6'b110000);
            if (i == 39) chk("pulse_idle", outv(), 6'b110001);
        end
        chk("pulse_ready_cycles", 6'(ready_cnt), 6'd1);

        // Re-request during HS_TRAIL waits for EXIT to finish.
        hs_req = 1'b1;
        tick(1);
        tick(15); chk("rereq_ready", outv(), 6'b001110);
        hs_req = 1'b0;
        tick(1);
        tick(17); chk("rereq_in_trail", outv(), 6'b001000);
        hs_req = 1'b1;
        tick(2);  chk("rereq_exit_start", outv(), 6'b110000);
        tick(3);  chk("rereq_exit_hold", outv(), 6'b110000);
        tick(1);  chk("rereq_idle", outv(), 6'b110001);
        tick(1);  chk("rereq_lp01", outv(), 6'b010000);
        tick(15); chk("rereq_ready_again", outv(), 6'b001110);

        // Reset mid-operation: straight back to LP-11, no trail.
        hs_req = 1'b0;
        tick(1);  chk("mid_post", outv(), 6'b001100);
        rst = 1'b1;
        tick(1);  chk("mid_reset", outv(), 6'b110001);
        rst = 1'b0;
        tick(3);  chk("mid_idle", outv(), 6'b110001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
